// File: rtl/rope_line_drawer.sv
// Rasterises the rope as a Bresenham line from a fixed pivot to the latched endpoint,
// first erasing the previous rope in the background colour, one pixel per clock.
module rope_line_drawer #(
    parameter int         ORIGIN_X    = 160,
    parameter int         ORIGIN_Y    = 45,
    parameter logic [2:0] ROPE_COLOUR = 3'b000,
    parameter logic [2:0] BG_COLOUR   = 3'b111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] end_x,
    input  logic [9:0] end_y,
    output logic       busy,
    output logic       done,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [2:0] {
        IDLE,
        ERASE_INIT,
        ERASE,
        DRAW_INIT,
        DRAW,
        FINISH
    } state_t;

    localparam logic [8:0]  ORIGIN_X9  = 9'(ORIGIN_X);
    localparam logic [7:0]  ORIGIN_Y8  = 8'(ORIGIN_Y);
    localparam logic [10:0] ORIGIN_X11 = 11'(ORIGIN_X);
    localparam logic [10:0] ORIGIN_Y11 = 11'(ORIGIN_Y);

    state_t             state_q, state_d;
    logic               prev_valid_q, prev_valid_d;
    logic [8:0]         prev_x_q, prev_x_d;
    logic [7:0]         prev_y_q, prev_y_d;
    logic [8:0]         new_x_q, new_x_d;
    logic [7:0]         new_y_q, new_y_d;
    logic [8:0]         cur_x_q, cur_x_d;
    logic [7:0]         cur_y_q, cur_y_d;
    logic [8:0]         tgt_x_q, tgt_x_d;
    logic [7:0]         tgt_y_q, tgt_y_d;
    logic signed [10:0] dx_q, dx_d;
    logic signed [10:0] dy_q, dy_d;
    logic               sx_neg_q, sx_neg_d;
    logic               sy_neg_q, sy_neg_d;
    logic signed [11:0] err_q, err_d;

    logic [8:0]         clamp_x;
    logic [7:0]         clamp_y;
    logic [8:0]         init_tx;
    logic [7:0]         init_ty;
    logic signed [10:0] diff_x;
    logic signed [10:0] diff_y;
    logic signed [12:0] e2;
    logic signed [12:0] dx_ext13;
    logic signed [12:0] dy_ext13;

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        prev_valid_d = prev_valid_q;
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        new_x_d      = new_x_q;
        new_y_d      = new_y_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        tgt_x_d      = tgt_x_q;
        tgt_y_d      = tgt_y_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        sx_neg_d     = sx_neg_q;
        sy_neg_d     = sy_neg_q;
        err_d        = err_q;

        clamp_x  = (end_x > 10'd319) ? 9'd319 : end_x[8:0];
        clamp_y  = (end_y > 10'd239) ? 8'd239 : end_y[7:0];
        init_tx  = (state_q == ERASE_INIT) ? prev_x_q : new_x_q;
        init_ty  = (state_q == ERASE_INIT) ? prev_y_q : new_y_q;
        diff_x   = $signed({2'b00, init_tx}) - $signed(ORIGIN_X11);
        diff_y   = $signed({3'b000, init_ty}) - $signed(ORIGIN_Y11);
        e2       = {err_q, 1'b0};
        dx_ext13 = {{2{dx_q[10]}}, dx_q};
        dy_ext13 = {{2{dy_q[10]}}, dy_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    new_x_d = clamp_x;
                    new_y_d = clamp_y;
                    state_d = prev_valid_q ? ERASE_INIT : DRAW_INIT;
                end
            end
            ERASE_INIT, DRAW_INIT: begin
                cur_x_d  = ORIGIN_X9;
                cur_y_d  = ORIGIN_Y8;
                tgt_x_d  = init_tx;
                tgt_y_d  = init_ty;
                dx_d     = diff_x[10] ? -diff_x : diff_x;
                dy_d     = diff_y[10] ? diff_y : -diff_y;
                sx_neg_d = diff_x[10];
                sy_neg_d = diff_y[10];
                err_d    = {dx_d[10], dx_d} + {dy_d[10], dy_d};
                state_d  = (state_q == ERASE_INIT) ? ERASE : DRAW;
            end
            ERASE, DRAW: begin
                if (cur_x_q == tgt_x_q && cur_y_q == tgt_y_q) begin
                    state_d = (state_q == ERASE) ? DRAW_INIT : FINISH;
                end else begin
                    // Both axis steps test the same e2, and their error updates add up.
                    if (e2 >= dy_ext13) begin
                        err_d   = err_d + {dy_q[10], dy_q};
                        cur_x_d = sx_neg_q ? cur_x_q - 9'd1 : cur_x_q + 9'd1;
                    end
                    if (e2 <= dx_ext13) begin
                        err_d   = err_d + {dx_q[10], dx_q};
                        cur_y_d = sy_neg_q ? cur_y_q - 8'd1 : cur_y_q + 8'd1;
                    end
                end
            end
            FINISH: begin
                prev_x_d     = new_x_q;
                prev_y_d     = new_y_q;
                prev_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == FINISH);
        vga_plot   = (state_q == ERASE) || (state_q == DRAW);
        vga_x      = vga_plot ? cur_x_q : 9'd0;
        vga_y      = vga_plot ? cur_y_q : 8'd0;
        vga_colour = (state_q == DRAW) ? ROPE_COLOUR : BG_COLOUR;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_valid_q <= 1'b0;
            prev_x_q     <= ORIGIN_X9;
            prev_y_q     <= ORIGIN_Y8;
            new_x_q      <= '0;
            new_y_q      <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            tgt_x_q      <= '0;
            tgt_y_q      <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            sx_neg_q     <= 1'b0;
            sy_neg_q     <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            prev_valid_q <= prev_valid_d;
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            tgt_x_q      <= tgt_x_d;
            tgt_y_q      <= tgt_y_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            sx_neg_q     <= sx_neg_d;
            sy_neg_q     <= sy_neg_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_rope_line_drawer.sv
// Scoreboard bench for rope_line_drawer: expected pixels are queued from a reference
// line model when a request is issued and popped as the DUT plots.
module tb_rope_line_drawer;

    localparam int         OX   = 160;
    localparam int         OY   = 45;
    localparam logic [2:0] ROPE = 3'b000;
    localparam logic [2:0] BG   = 3'b111;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] end_x;
    logic [9:0] end_y;
    logic       busy;
    logic       done;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    rope_line_drawer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .end_x      (end_x),
        .end_y      (end_y),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        int latency;
        int n_bg;
        int n_rope;
        int n_done;
        int last_x;
        int last_y;
    } res_t;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   m_prev_valid = 1'b0;
    int   m_prev_x = OX;
    int   m_prev_y = OY;

    // Textbook integer Bresenham from the pivot to (x1,y1).
    task automatic gen_line(input int x1, input int y1, input logic [2:0] c, output int n);
        int x, y, dx, dy, sx, sy, err, e2;
        pix_t p;
        x   = OX;
        y   = OY;
        dx  = (x1 > OX) ? x1 - OX : OX - x1;
        dy  = -((y1 > OY) ? y1 - OY : OY - y1);
        sx  = (x1 < OX) ? -1 : 1;
        sy  = (y1 < OY) ? -1 : 1;
        err = dx + dy;
        n   = 0;
        while (1) begin
            p.x = 9'(x);
            p.y = 8'(y);
            p.c = c;
            exp_q.push_back(p);
            n++;
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // Issues one request and monitors it; optional mid-run start pulse or reset.
    task automatic run_request(input int ex, input int ey, input int pulse_cyc,
                               input int reset_cyc, output res_t r);
        int   cx, cy, ne, nd, exp_lat;
        pix_t p;
        cx = (ex > 319) ? 319 : ex;
        cy = (ey > 239) ? 239 : ey;
        ne = 0;
        if (m_prev_valid) gen_line(m_prev_x, m_prev_y, BG, ne);
        gen_line(cx, cy, ROPE, nd);
        exp_lat = (m_prev_valid ? 1 + ne : 0) + 1 + nd + 1;
        r = '{latency: -1, n_bg: 0, n_rope: 0, n_done: 0, last_x: -1, last_y: -1};

        @(negedge clock);
        end_x = 10'(ex);
        end_y = 10'(ey);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;

        for (int cyc = 1; cyc <= exp_lat + 4; cyc++) begin
            if (r.latency < 0) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_high cyc=%0d got=%b want=1", cyc, busy);
                end
            end
            if (vga_plot === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_plot cyc=%0d got=(%0d,%0d,%0d) want=none",
                             cyc, vga_x, vga_y, vga_colour);
                end else begin
                    p = exp_q.pop_front();
                    if ({vga_x, vga_y, vga_colour} !== {p.x, p.y, p.c}) begin
                        n_fail++;
                        $display("FAIL pixel cyc=%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                                 cyc, vga_x, vga_y, vga_colour, p.x, p.y, p.c);
                    end
                end
                if (vga_colour === BG) r.n_bg++;
                if (vga_colour === ROPE) r.n_rope++;
                r.last_x = int'(vga_x);
                r.last_y = int'(vga_y);
            end
            if (done === 1'b1) begin
                r.n_done++;
                n_checks++;
                if (vga_plot !== 1'b0) begin
                    n_fail++;
                    $display("FAIL plot_at_done cyc=%0d got=%b want=0", cyc, vga_plot);
                end
                if (r.latency < 0) r.latency = cyc;
            end
            if (cyc == reset_cyc) begin
                reset = 1'b1;
                @(negedge clock);
                n_checks++;
                if (vga_plot !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid got plot=%b busy=%b want plot=0 busy=0",
                             vga_plot, busy);
                end
                reset = 1'b0;
                exp_q.delete();
                m_prev_valid = 1'b0;
                m_prev_x = OX;
                m_prev_y = OY;
                return;
            end
            if (cyc == pulse_cyc) begin
                start = 1'b1;
                end_x = 10'd5;
            end else if (cyc == pulse_cyc + 1) begin
                start = 1'b0;
            end
            @(negedge clock);
        end

        n_checks++;
        if (r.latency != exp_lat) begin
            n_fail++;
            $display("FAIL latency got=%0d want=%0d", r.latency, exp_lat);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_plots got=%0d_left want=0", exp_q.size());
        end
        n_checks++;
        if (r.n_done != 1) begin
            n_fail++;
            $display("FAIL done_pulses got=%0d want=1", r.n_done);
        end
        exp_q.delete();
        m_prev_valid = 1'b1;
        m_prev_x = cx;
        m_prev_y = cy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        end_x = '0;
        end_y = '0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({busy, done, vga_plot, vga_x, vga_y, vga_colour} !== {3'b000, 9'd0, 8'd0, BG}) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b%b%b x=%0d y=%0d c=%0d want 000 x=0 y=0 c=%0d",
                     busy, done, vga_plot, vga_x, vga_y, vga_colour, BG);
        end
        reset = 1'b0;
    endtask

    task automatic test_vertical();
        res_t r;
        run_request(160, 100, 0, 0, r);
        n_checks++;
        if (r.latency != 58 || r.n_rope != 56 || r.n_bg != 0) begin
            n_fail++;
            $display("FAIL vertical got lat=%0d rope=%0d bg=%0d want lat=58 rope=56 bg=0",
                     r.latency, r.n_rope, r.n_bg);
        end
    endtask

    task automatic test_diagonal();
        res_t r;
        run_request(170, 55, 0, 0, r);
        n_checks++;
        if (r.latency != 70 || r.n_bg != 56 || r.n_rope != 11) begin
            n_fail++;
            $display("FAIL diagonal got lat=%0d bg=%0d rope=%0d want lat=70 bg=56 rope=11",
                     r.latency, r.n_bg, r.n_rope);
        end
    endtask

    task automatic test_horizontal_left();
        res_t r;
        run_request(100, 45, 0, 0, r);
        n_checks++;
        if (r.latency != 75 || r.n_bg != 11 || r.n_rope != 61 || r.last_x != 100 || r.last_y != 45) begin
            n_fail++;
            $display("FAIL horiz_left got lat=%0d bg=%0d rope=%0d end=(%0d,%0d) want 75 11 61 (100,45)",
                     r.latency, r.n_bg, r.n_rope, r.last_x, r.last_y);
        end
    endtask

    task automatic test_steep();
        res_t r;
        run_request(163, 54, 0, 0, r);
        n_checks++;
        if (r.latency != 74 || r.n_rope != 10 || r.last_x != 163 || r.last_y != 54) begin
            n_fail++;
            $display("FAIL steep got lat=%0d rope=%0d end=(%0d,%0d) want 74 10 (163,54)",
                     r.latency, r.n_rope, r.last_x, r.last_y);
        end
    endtask

    task automatic test_clamp();
        res_t r;
        run_request(400, 300, 0, 0, r);
        n_checks++;
        if (r.latency != 208 || r.n_rope != 195 || r.last_x != 319 || r.last_y != 239) begin
            n_fail++;
            $display("FAIL clamp got lat=%0d rope=%0d end=(%0d,%0d) want 208 195 (319,239)",
                     r.latency, r.n_rope, r.last_x, r.last_y);
        end
    endtask

    task automatic test_start_ignored();
        res_t r;
        run_request(160, 100, 220, 0, r);
        n_checks++;
        if (r.latency != 254 || r.n_done != 1 || r.last_x != 160 || r.last_y != 100) begin
            n_fail++;
            $display("FAIL start_ignored got lat=%0d dones=%0d end=(%0d,%0d) want 254 1 (160,100)",
                     r.latency, r.n_done, r.last_x, r.last_y);
        end
    endtask

    task automatic test_reset_mid_draw();
        res_t r;
        run_request(170, 55, 0, 62, r);
        run_request(160, 46, 0, 0, r);
        n_checks++;
        if (r.latency != 4 || r.n_rope != 2 || r.n_bg != 0) begin
            n_fail++;
            $display("FAIL after_reset got lat=%0d rope=%0d bg=%0d want 4 2 0",
                     r.latency, r.n_rope, r.n_bg);
        end
    endtask

    initial begin
        test_reset();
        test_vertical();
        test_diagonal();
        test_horizontal_left();
        test_steep();
        test_clamp();
        test_start_ignored();
        test_reset_mid_draw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rope_line_drawer.md
Name: rope_line_drawer

Overview:
- Downstream consumer of the rope controller's endX/endY. Rasterises the rope as a straight line from a fixed origin to the current rope endpoint into the 320x240 VGA framebuffer.
- Uses a Bresenham stepper, one pixel per clock.
- Each request first erases the previously drawn rope by redrawing it in the background colour, then draws the new rope in the rope colour.
- Sits between the rope controller and the VGA adapter's pixel-write port.

Parameters:
- ORIGIN_X, 160, rope pivot x (77 / 237 for two-player instances)
- ORIGIN_Y, 45, rope pivot y
- ROPE_COLOUR, 3'b000, colour written when drawing
- BG_COLOUR, 3'b111, colour written when erasing

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request to redraw; sampled only in IDLE
- end_x  input  10  rope endpoint x (rope controller endX)
- end_y  input  10  rope endpoint y (rope controller endY)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when a redraw completes
- vga_x  output  9  pixel x to VGA adapter
- vga_y  output  8  pixel y to VGA adapter
- vga_colour  output  3  pixel colour
- vga_plot  output  1  write strobe; the pixel is written on each cycle it is high

Behaviour:
- Clock and reset: single clock, named clock. Reset is synchronous and active-high, named reset.
- Reset values: busy=0, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=BG_COLOUR. State=IDLE, prev_valid=0, prev_x=ORIGIN_X, prev_y=ORIGIN_Y.
- Input clamp at latch: x = min(end_x, 319), y = min(end_y, 239).
- States: IDLE, ERASE_INIT, ERASE, DRAW_INIT, DRAW, FINISH.
- IDLE:
  - start=1 latches the clamped (new_x, new_y).
  - Next state is ERASE_INIT if prev_valid, else DRAW_INIT.
  - start in any other state is ignored; there is no queueing.
- *_INIT (1 cycle, vga_plot=0):
  - Load cur=(ORIGIN_X, ORIGIN_Y), target = (prev_x, prev_y) for erase or (new_x, new_y) for draw.
  - dx = |tx-ORIGIN_X| (11-bit signed); dy = -|ty-ORIGIN_Y| (11-bit signed).
  - sx, sy = +1/-1 toward the target (+1 when equal).
  - err = dx + dy (12-bit signed).
- ERASE / DRAW (one cycle per pixel):
  - vga_plot=1, vga_x/vga_y = cur, vga_colour = BG_COLOUR (erase) or ROPE_COLOUR (draw).
  - If cur == target, leave to DRAW_INIT (from ERASE) or FINISH (from DRAW).
  - Otherwise, with e2 = 2*err:
    - if e2 >= dy: err += dy, cur_x += sx;
    - if e2 <= dx: err += dx, cur_y += sy.
    - Both updates may apply in the same cycle; the err updates accumulate.
- Pixel count per line: N = max(|dx|,|dy|) + 1. The origin and the endpoint are both plotted exactly once. A degenerate line with endpoint = origin gives N=1.
- FINISH (1 cycle):
  - done=1, vga_plot=0.
  - prev_x/prev_y <= new_x/new_y, prev_valid <= 1.
  - Next state is IDLE.
- Latency from the start-sampling edge to the done cycle: (prev_valid ? 1+N_erase : 0) + 1 + N_draw + 1 cycles.
- end_x/end_y may change while busy; only the value latched at start is used.
- Reset mid-operation:
  - Immediate return to IDLE with vga_plot=0 on the next cycle.
  - prev_valid is cleared, so the next request skips the erase. Clearing any partial line on screen is the background renderer's job.
- vga_plot is never high in IDLE, *_INIT or FINISH.

Test Plan:
- After reset, start with end=(160,100) -> no erase phase; DRAW_INIT then 56 plot cycles with x=160 and y=45..100 ascending, colour ROPE_COLOUR; done 1 cycle later (58 cycles total); busy high throughout.
- Then start with end=(170,55) -> 56 erase plots with BG_COLOUR along x=160, y=45..100, then 11 draw plots (160,45),(161,46)..(170,55); done at cycle 1+56+1+11+1 = 70.
- Then start with end=(100,45) -> erase of the diagonal (11 plots), then 61 draw plots with y=45 and x descending 160..100; stepping check sx=-1.
- Steep case end=(163,54) and clamp case end=(400,300) -> 10 plots, x non-decreasing, each step y+1, ending at (163,54). The clamp case is drawn to (319,239), and the final plot equals (319,239).
- Start pulsed again during DRAW, and end_x changed mid-draw -> ignored: the pixel sequence and done timing are unchanged, with exactly one done pulse.
- Reset asserted during DRAW -> vga_plot=0 and busy=0 the following cycle. A subsequent start with end=(160,46) draws 2 pixels with no erase phase.
